// File: rtl/gf180mcu_osu_sc_sigrx_pkg.sv
// rtl/gf180mcu_osu_sc_sigrx_pkg.sv - shared types and defaults for the sigrx receiver
//
// Purpose: filter FSM state encoding and default parameter values used by
// gf180mcu_osu_sc_12t_sigrx.
// Ports: none (package).
package gf180mcu_osu_sc_sigrx_pkg;

  typedef enum logic [1:0] {
    LO      = 2'd0,
    PEND_HI = 2'd1,
    HI      = 2'd2,
    PEND_LO = 2'd3
  } filt_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_CYCLES = 4;

endpackage

// File: rtl/gf180mcu_osu_sc_12T_sync.sv
// rtl/gf180mcu_osu_sc_12T_sync.sv - N-flop synchronizer with async active-low reset
//
// Purpose: brings an asynchronous single-bit net into the clk domain.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   d     - asynchronous input
//   q     - synchronized output (last stage)
module gf180mcu_osu_sc_12T_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Pure flop chain: nothing may sit between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gf180mcu_osu_sc_12t_sigrx.sv
// rtl/gf180mcu_osu_sc_12t_sigrx.sv - synchronizing glitch-filter receiver with event register
//
// Purpose: synchronizes A, accepts a new level only after it persists for
// FILT_CYCLES cycles, and reports each accepted change through a one-entry
// valid/ack event register with a sticky overflow flag.
// Ports:
//   CLK       - clock
//   RN        - asynchronous active-low reset
//   A         - asynchronous input net
//   Y         - filtered, synchronized level
//   RISE/FALL - one-cycle pulses on accepted 0->1 / 1->0 changes
//   EVT_VALID - an event is pending
//   EVT_RISE  - direction of the pending event (1 = rise)
//   EVT_ACK   - consumer accepts the pending event
//   OVF       - sticky: an event was dropped
//   OVF_CLR   - clears OVF (a simultaneous drop wins)
module gf180mcu_osu_sc_12t_sigrx
  import gf180mcu_osu_sc_sigrx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES
) (
  input  logic CLK,
  input  logic RN,
  input  logic A,
  output logic Y,
  output logic RISE,
  output logic FALL,
  output logic EVT_VALID,
  output logic EVT_RISE,
  input  logic EVT_ACK,
  output logic OVF,
  input  logic OVF_CLR
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  logic          s;
  filt_state_t   state;
  logic [CW-1:0] cnt;
  logic          cnt_done;
  logic          accept_rise;
  logic          accept_fall;
  logic          accept;

  gf180mcu_osu_sc_12T_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst_n(RN),
    .d    (A),
    .q    (s)
  );

  // Acceptance is decided combinationally so the FSM and the event register
  // see the same change on the same edge. With FILT_CYCLES==1 the stable
  // states accept directly and the pending states are never entered.
  always_comb begin
    cnt_done    = (int'(cnt) + 1) == FILT_CYCLES;
    accept_rise = s  && (((state == LO) && (FILT_CYCLES == 1)) ||
                         ((state == PEND_HI) && cnt_done));
    accept_fall = !s && (((state == HI) && (FILT_CYCLES == 1)) ||
                         ((state == PEND_LO) && cnt_done));
    accept      = accept_rise || accept_fall;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= LO;
      cnt   <= '0;
      Y     <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      RISE <= accept_rise;
      FALL <= accept_fall;
      case (state)
        LO: begin
          if (accept_rise) begin
            state <= HI;
            cnt   <= '0;
            Y     <= 1'b1;
          end else if (s) begin
            state <= PEND_HI;
            cnt   <= CW'(1);
          end
        end
        PEND_HI: begin
          if (!s) begin
            state <= LO;
            cnt   <= '0;
          end else if (accept_rise) begin
            state <= HI;
            cnt   <= '0;
            Y     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HI: begin
          if (accept_fall) begin
            state <= LO;
            cnt   <= '0;
            Y     <= 1'b0;
          end else if (!s) begin
            state <= PEND_LO;
            cnt   <= CW'(1);
          end
        end
        PEND_LO: begin
          if (s) begin
            state <= HI;
            cnt   <= '0;
          end else if (accept_fall) begin
            state <= LO;
            cnt   <= '0;
            Y     <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= LO;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A new event replaces the pending one only if the slot is empty or is
  // being acknowledged on this very edge; otherwise it is dropped.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      EVT_VALID <= 1'b0;
      EVT_RISE  <= 1'b0;
      OVF       <= 1'b0;
    end else begin
      if (accept && (!EVT_VALID || EVT_ACK)) begin
        EVT_VALID <= 1'b1;
        EVT_RISE  <= accept_rise;
      end else if (EVT_ACK) begin
        EVT_VALID <= 1'b0;
      end

      if (accept && EVT_VALID && !EVT_ACK) begin
        OVF <= 1'b1;
      end else if (OVF_CLR) begin
        OVF <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gf180mcu_osu_sc_12t_sigrx.md
# gf180mcu_osu_sc_12T_sigrx

Receive-side counterpart to the library's buffer/driver cells. It captures an asynchronous single-bit net driven across a long buffered route, synchronizes it into the `CLK` domain, and rejects glitches shorter than a programmable number of cycles. It reports each accepted level change through a one-entry valid/ack event register with sticky overflow. It sits at the load end of buffered control/status nets, in front of any synchronous consumer.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops; legal values ≥ 2.
- `FILT_CYCLES`, default 4: consecutive cycles a new level must persist before it is accepted; legal values ≥ 1.
- `CLK` input, 1 bit: sole clock; all state updates on the rising edge.
- `RN` input, 1 bit: asynchronous, active-low reset.
- `A` input, 1 bit: asynchronous net from the buffered route.
- `Y` output, 1 bit: filtered, synchronized level.
- `RISE` output, 1 bit: one-cycle pulse on an accepted 0→1 change.
- `FALL` output, 1 bit: one-cycle pulse on an accepted 1→0 change.
- `EVT_VALID` output, 1 bit: an event is pending.
- `EVT_RISE` output, 1 bit: type of the pending event; 1 = rise, 0 = fall. Meaningful only while `EVT_VALID` is 1.
- `EVT_ACK` input, 1 bit: consumer accepts the pending event.
- `OVF` output, 1 bit: sticky flag; an event was dropped.
- `OVF_CLR` input, 1 bit: clears `OVF`.

## Operation
- **Reset:** `RN` low asynchronously forces the following, regardless of `A`:
  - all synchronizer flops to 0;
  - `Y`, `RISE`, `FALL`, `EVT_VALID`, `EVT_RISE` and `OVF` to 0;
  - the filter counter to 0;
  - the FSM to `LO`.
- **Synchronizer:** a chain of `SYNC_STAGES` flops. The last stage is `S`. No logic sits between stages.
- **Filter FSM** (states `LO`, `PEND_HI`, `HI`, `PEND_LO`; counter width `$clog2(FILT_CYCLES+1)`):
  - `LO`:
    - `S`=1 → go to `PEND_HI`, counter=1.
    - If `FILT_CYCLES`==1, go directly to `HI` with a rise instead.
  - `PEND_HI`:
    - `S`=0 → return to `LO`, counter=0. This is a glitch; no output change.
    - `S`=1 and counter+1==`FILT_CYCLES` → go to `HI`, `Y`←1, `RISE`=1 for one cycle.
    - Otherwise, increment the counter.
  - `HI` and `PEND_LO` are the mirror image: they produce `Y`←0 and a `FALL` pulse.
- **Event register:**
  - An accepted change while `EVT_VALID`=0 → `EVT_VALID`←1 and `EVT_RISE`←direction of the change.
  - `EVT_ACK`=1 while `EVT_VALID`=1 → `EVT_VALID`←0.
  - `EVT_ACK` while `EVT_VALID`=0 is ignored.
  - Accepted change and `EVT_ACK` on the same edge → the new event is loaded, `EVT_VALID` stays 1, and `EVT_RISE` takes the new direction.
  - Accepted change while `EVT_VALID`=1 and no `EVT_ACK` → the new event is dropped, the pending event is unchanged, and `OVF`←1.
- **`OVF`:**
  - `OVF_CLR`=1 → `OVF`←0.
  - If a drop and `OVF_CLR` occur on the same edge, the set wins and `OVF`=1.
- **Reset mid-operation:** pending filter progress and any pending event are discarded. After `RN` is released, `A`=1 is treated as a fresh rise and passes through the full filter.

## Timing
- **Latency:** number the first rising edge that samples a new, stable `A` level as edge 1.
  - `Y` updates at edge `SYNC_STAGES`+`FILT_CYCLES` (edge 6 with the defaults).
  - `RISE`/`FALL` and `EVT_VALID` update on the same edge as `Y`.
- **Glitch rejection:** any `S` excursion lasting fewer than `FILT_CYCLES` cycles produces no `Y` change and no event.
- **Pulse width:** `RISE`/`FALL` are exactly one cycle wide.
- **Repeated changes:** the minimum spacing between two accepted changes is `FILT_CYCLES` cycles.
- **Handshake:** `EVT_ACK` is sampled on the rising edge. `EVT_VALID` falls on the edge after the ack, unless a new event loads on that same edge.
- **Registered outputs:** all outputs are driven directly from flops.

## Structure
- **Package `gf180mcu_osu_sc_sigrx_pkg`:** filter FSM state enum (`LO`, `PEND_HI`, `HI`, `PEND_LO`) and default parameter constants.
- **Sub-module `gf180mcu_osu_sc_12T_sync`:** parameterized N-flop synchronizer with async active-low reset to 0. It is instantiated once here and reused elsewhere.
- **Top level:** filter FSM, counter, event register and `OVF` logic.

## Test plan
- **Reset with `A`=1:** hold `RN`=0 with `A`=1 → all outputs 0. Release `RN` → `Y`=1 at edge 6, `RISE` pulse, `EVT_VALID`=1, `EVT_RISE`=1.
- **Glitch rejection:** `A` high for 3 cycles, then low (defaults) → `Y` stays 0, no `RISE`, `EVT_VALID` stays 0. Repeat with 4 cycles → `Y`=1.
- **Rise then fall:** rise and fall each held ≥ 6 cycles, with `EVT_ACK` pulsed 1 cycle after each `EVT_VALID` → two events, `EVT_RISE`=1 then 0, `OVF`=0.
- **Overflow:** rise accepted, no ack, then fall accepted → `EVT_VALID`=1, `EVT_RISE` still 1, `OVF`=1. Then `OVF_CLR` together with a third dropped edge → `OVF` remains 1. Then `OVF_CLR` alone → `OVF`=0.
- **Ack and new event on the same edge:** `EVT_ACK`=1 on the edge the fall is accepted → `EVT_VALID` stays 1, `EVT_RISE`=0, `OVF`=0.
- **Reset mid-filter:** assert `RN` while the FSM is in `PEND_HI` with counter=2 → outputs 0 immediately. After release with `A` still 1 → full 6-edge latency to `Y`=1.
